// File: rtl/fwrisc_wb_arb2.sv
// Two-requester Wishbone arbiter: instruction and data initiators share one bus.
// Grant is registered and round-robin under contention, with a bus-timeout watchdog.
module fwrisc_wb_arb2 #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   wbi_adr,
   input  logic [DATA_WIDTH-1:0]   wbi_dat_w,
   input  logic [DATA_WIDTH/8-1:0] wbi_sel,
   input  logic                    wbi_we,
   input  logic                    wbi_cyc,
   input  logic                    wbi_stb,
   output logic [DATA_WIDTH-1:0]   wbi_dat_r,
   output logic                    wbi_ack,
   output logic                    wbi_err,
   input  logic [ADDR_WIDTH-1:0]   wbd_adr,
   input  logic [DATA_WIDTH-1:0]   wbd_dat_w,
   input  logic [DATA_WIDTH/8-1:0] wbd_sel,
   input  logic                    wbd_we,
   input  logic                    wbd_cyc,
   input  logic                    wbd_stb,
   output logic [DATA_WIDTH-1:0]   wbd_dat_r,
   output logic                    wbd_ack,
   output logic                    wbd_err,
   output logic [ADDR_WIDTH-1:0]   wb_adr,
   output logic [DATA_WIDTH-1:0]   wb_dat_w,
   output logic [DATA_WIDTH/8-1:0] wb_sel,
   output logic                    wb_we,
   output logic                    wb_cyc,
   output logic                    wb_stb,
   input  logic [DATA_WIDTH-1:0]   wb_dat_r,
   input  logic                    wb_ack,
   input  logic                    wb_err
);

   localparam int   CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic TMO_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

   state_t        state, state_nxt;
   logic          last_d, last_d_nxt;
   logic [CW-1:0] cnt;
   logic          gnt_i, gnt_d, tmo;

   assign gnt_i = (state == GNT_I);
   assign gnt_d = (state == GNT_D);

   // A response in the same cycle as the limit completes the beat, so it beats the timeout.
   assign tmo = TMO_EN && (gnt_i || gnt_d) && (cnt == CW'(TIMEOUT)) && !wb_ack && !wb_err;

   always_comb begin
      state_nxt  = state;
      last_d_nxt = last_d;
      case (state)
         IDLE: begin
            if (wbi_cyc && (!wbd_cyc || last_d)) begin
               state_nxt  = GNT_I;
               last_d_nxt = 1'b0;
            end else if (wbd_cyc) begin
               state_nxt  = GNT_D;
               last_d_nxt = 1'b1;
            end
         end
         GNT_I: begin
            if (tmo) state_nxt = ABORT;
            else if (!wbi_cyc) begin
               if (wbd_cyc) begin
                  state_nxt  = GNT_D;
                  last_d_nxt = 1'b1;
               end else state_nxt = IDLE;
            end
         end
         GNT_D: begin
            if (tmo) state_nxt = ABORT;
            else if (!wbd_cyc) begin
               if (wbi_cyc) begin
                  state_nxt  = GNT_I;
                  last_d_nxt = 1'b0;
               end else state_nxt = IDLE;
            end
         end
         default: begin
            // last_d names the aborted requester; wait for it to release the bus
            if (last_d ? !wbd_cyc : !wbi_cyc) begin
               if (last_d && wbi_cyc) begin
                  state_nxt  = GNT_I;
                  last_d_nxt = 1'b0;
               end else if (!last_d && wbd_cyc) begin
                  state_nxt  = GNT_D;
                  last_d_nxt = 1'b1;
               end else state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         last_d <= 1'b1;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         last_d <= last_d_nxt;
         if (state_nxt != state || wb_ack || wb_err) cnt <= '0;
         else if (TMO_EN && (gnt_i || gnt_d) && wb_stb) cnt <= cnt + CW'(1);
      end
   end

   assign wb_adr   = gnt_d ? wbd_adr   : wbi_adr;
   assign wb_dat_w = gnt_d ? wbd_dat_w : wbi_dat_w;
   assign wb_sel   = gnt_d ? wbd_sel   : wbi_sel;
   assign wb_we    = gnt_d ? wbd_we    : wbi_we;
   assign wb_cyc   = (gnt_i && wbi_cyc) || (gnt_d && wbd_cyc);
   assign wb_stb   = (gnt_i && wbi_stb) || (gnt_d && wbd_stb);

   assign wbi_dat_r = wb_dat_r;
   assign wbd_dat_r = wb_dat_r;
   assign wbi_ack   = gnt_i && wb_ack;
   assign wbd_ack   = gnt_d && wb_ack;
   assign wbi_err   = gnt_i && (wb_err || tmo);
   assign wbd_err   = gnt_d && (wb_err || tmo);

endmodule

// File: tb/tb_fwrisc_wb_arb2.sv
// Directed bench for fwrisc_wb_arb2: per-cycle vector table plus hand sequences
// for timeout, ack/timeout collision and asynchronous reset.
module tb_fwrisc_wb_arb2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] wbi_adr = 32'h100, wbd_adr = 32'h200;
   logic [31:0] wbi_dat_w = 32'h11, wbd_dat_w = 32'h22;
   logic [3:0]  wbi_sel = 4'hf, wbd_sel = 4'h3;
   logic        wbi_we = 1'b0, wbd_we = 1'b1;
   logic        wbi_cyc = 1'b0, wbi_stb = 1'b0, wbd_cyc = 1'b0, wbd_stb = 1'b0;
   logic [31:0] wb_dat_r = 32'h13;
   logic        wb_ack = 1'b0, wb_err = 1'b0;

   logic [31:0] wbi_dat_r, wbd_dat_r, wb_adr, wb_dat_w;
   logic [3:0]  wb_sel;
   logic        wbi_ack, wbi_err, wbd_ack, wbd_err, wb_we, wb_cyc, wb_stb;
   // second instance (TIMEOUT=3) shares the stimulus
   logic [31:0] t3_wbi_dat_r, t3_wbd_dat_r, t3_wb_adr, t3_wb_dat_w;
   logic [3:0]  t3_wb_sel;
   logic        t3_wbi_ack, t3_wbi_err, t3_wbd_ack, t3_wbd_err, t3_wb_we, t3_wb_cyc, t3_wb_stb;

   always #5 clock = ~clock;

   fwrisc_wb_arb2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clock(clock), .reset(reset),
      .wbi_adr(wbi_adr), .wbi_dat_w(wbi_dat_w), .wbi_sel(wbi_sel), .wbi_we(wbi_we),
      .wbi_cyc(wbi_cyc), .wbi_stb(wbi_stb), .wbi_dat_r(wbi_dat_r), .wbi_ack(wbi_ack), .wbi_err(wbi_err),
      .wbd_adr(wbd_adr), .wbd_dat_w(wbd_dat_w), .wbd_sel(wbd_sel), .wbd_we(wbd_we),
      .wbd_cyc(wbd_cyc), .wbd_stb(wbd_stb), .wbd_dat_r(wbd_dat_r), .wbd_ack(wbd_ack), .wbd_err(wbd_err),
      .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err)
   );

   fwrisc_wb_arb2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(3)) dut3 (
      .clock(clock), .reset(reset),
      .wbi_adr(wbi_adr), .wbi_dat_w(wbi_dat_w), .wbi_sel(wbi_sel), .wbi_we(wbi_we),
      .wbi_cyc(wbi_cyc), .wbi_stb(wbi_stb), .wbi_dat_r(t3_wbi_dat_r), .wbi_ack(t3_wbi_ack), .wbi_err(t3_wbi_err),
      .wbd_adr(wbd_adr), .wbd_dat_w(wbd_dat_w), .wbd_sel(wbd_sel), .wbd_we(wbd_we),
      .wbd_cyc(wbd_cyc), .wbd_stb(wbd_stb), .wbd_dat_r(t3_wbd_dat_r), .wbd_ack(t3_wbd_ack), .wbd_err(t3_wbd_err),
      .wb_adr(t3_wb_adr), .wb_dat_w(t3_wb_dat_w), .wb_sel(t3_wb_sel), .wb_we(t3_wb_we),
      .wb_cyc(t3_wb_cyc), .wb_stb(t3_wb_stb), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err)
   );

   // in = {ic, is, dc, ds, ack, err}; src 0 = bus idle, 1 = instr, 2 = data;
   // out = {stb, iack, ierr, dack, derr}
   typedef struct packed {
      logic [5:0] in;
      logic [1:0] src;
      logic [4:0] out;
   } vec_t;

   vec_t tv[29];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [5:0] v);
      {wbi_cyc, wbi_stb, wbd_cyc, wbd_stb, wb_ack, wb_err} = v;
   endtask

   initial begin
      // contention after reset: instr first, data follows without a bubble
      tv[0]  = '{6'b111100, 2'd0, 5'b00000};
      tv[1]  = '{6'b111100, 2'd1, 5'b10000};
      tv[2]  = '{6'b111110, 2'd1, 5'b11000};
      tv[3]  = '{6'b001100, 2'd0, 5'b00000};
      tv[4]  = '{6'b001100, 2'd2, 5'b10000};
      tv[5]  = '{6'b001110, 2'd2, 5'b10010};
      tv[6]  = '{6'b000000, 2'd0, 5'b00000};
      // lone instruction fetch
      tv[7]  = '{6'b110000, 2'd0, 5'b00000};
      tv[8]  = '{6'b110000, 2'd1, 5'b10000};
      tv[9]  = '{6'b110010, 2'd1, 5'b11000};
      tv[10] = '{6'b000000, 2'd0, 5'b00000};
      // repeated contention: data first now
      tv[11] = '{6'b111100, 2'd0, 5'b00000};
      tv[12] = '{6'b111100, 2'd2, 5'b10000};
      tv[13] = '{6'b111110, 2'd2, 5'b10010};
      tv[14] = '{6'b110000, 2'd0, 5'b00000};
      tv[15] = '{6'b110000, 2'd1, 5'b10000};
      tv[16] = '{6'b110010, 2'd1, 5'b11000};
      tv[17] = '{6'b000000, 2'd0, 5'b00000};
      // data lock across stb gap while instr waits; then ack+err together
      tv[18] = '{6'b111100, 2'd0, 5'b00000};
      tv[19] = '{6'b111100, 2'd2, 5'b10000};
      tv[20] = '{6'b111110, 2'd2, 5'b10010};
      tv[21] = '{6'b111000, 2'd2, 5'b00000};
      tv[22] = '{6'b111100, 2'd2, 5'b10000};
      tv[23] = '{6'b111110, 2'd2, 5'b10010};
      tv[24] = '{6'b110000, 2'd0, 5'b00000};
      tv[25] = '{6'b110000, 2'd1, 5'b10000};
      tv[26] = '{6'b110011, 2'd1, 5'b11100};
      tv[27] = '{6'b000000, 2'd0, 5'b00000};
      tv[28] = '{6'b000001, 2'd0, 5'b00000};

      // reset state, with requests and a response already present
      drive(6'b111110);
      #12;
      chk("reset_outputs", {wb_cyc, wb_stb, wbi_ack, wbi_err, wbd_ack, wbd_err}, 6'b0);
      drive(6'b000000);
      @(negedge clock);
      reset = 1'b1;
      tick();

      for (int k = 0; k < 29; k++) begin
         drive(tv[k].in);
         @(negedge clock);
         chk($sformatf("vec%0d", k),
             {wb_cyc, wb_stb, wbi_ack, wbi_err, wbd_ack, wbd_err},
             {tv[k].src != 2'd0, tv[k].out});
         if (tv[k].src != 2'd0)
            chk($sformatf("vec%0d_adr_we", k), {wb_adr, 31'd0, wb_we},
                (tv[k].src == 2'd1) ? {32'h100, 31'd0, 1'b0} : {32'h200, 31'd0, 1'b1});
         tick();
      end
      chk("dat_r_route", {wbi_dat_r, wbd_dat_r}, {32'h13, 32'h13});

      // ack arriving the cycle the TIMEOUT=3 counter reaches its limit
      drive(6'b001100);
      tick(); tick(); tick(); tick();
      drive(6'b001110);
      @(negedge clock);
      chk("coll_ack_err", {t3_wbd_ack, t3_wbd_err, t3_wbi_ack}, 3'b100);
      tick();
      drive(6'b001000);
      @(negedge clock);
      chk("coll_still_gnt", {t3_wb_cyc, t3_wbd_err}, 2'b10);
      tick();
      @(negedge clock);
      chk("coll_hold", {t3_wb_cyc, t3_wbd_err}, 2'b10);
      tick();
      drive(6'b000000);
      tick(); tick();

      // TIMEOUT=4 watchdog: target never acks
      drive(6'b001100);
      tick();
      @(negedge clock);
      chk("tmo_stb_on_bus", {wb_cyc, wb_stb}, 2'b11);
      tick(); tick(); tick();
      @(negedge clock);
      chk("tmo_no_early_err", wbd_err, 1'b0);
      tick();
      @(negedge clock);
      chk("tmo_err", {wbd_err, wbi_err, wb_cyc}, 3'b101);
      tick();
      drive(6'b001110);
      @(negedge clock);
      chk("tmo_abort_late_ack", {wb_cyc, wb_stb, wbd_ack, wbd_err}, 4'b0000);
      tick();
      drive(6'b000000);
      tick(); tick();
      @(negedge clock);
      chk("tmo_recovered", wb_cyc, 1'b0);
      tick();

      // asynchronous reset during a granted transfer
      drive(6'b001100);
      tick();
      chk("rst_pre_gnt", wb_cyc, 1'b1);
      #2;
      reset = 1'b0;
      wb_ack = 1'b1;
      #1;
      chk("rst_async_drop", {wb_cyc, wb_stb, wbd_ack, wbd_err, wbi_ack, wbi_err}, 6'b0);
      wb_ack = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_release_no_gnt", wb_cyc, 1'b0);
      tick();
      chk("rst_regrant", {wb_cyc, wb_stb, wb_adr}, {2'b11, 32'h200});
      drive(6'b000000);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/fwrisc_wb_arb2.md
FWRISC_WB_ARB2 -- requirements
Module: fwrisc_wb_arb2

Two-requester Wishbone arbiter. It merges the core's instruction initiator (wbi_) and data initiator (wbd_) onto one shared Wishbone initiator port (wb_), with a bus-timeout watchdog.

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32: data width of all ports; sel width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 255: cycles a granted strobe may wait for ack/err before abort; 0 disables the watchdog.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 wbi_adr/dat_w/sel/we/cyc/stb  in  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1/1/1  instruction-side request.
REQ-007 wbi_dat_r/ack/err  out  DATA_WIDTH/1/1  instruction-side response.
REQ-008 wbd_adr/dat_w/sel/we/cyc/stb  in  (same widths as REQ-006)  data-side request.
REQ-009 wbd_dat_r/ack/err  out  DATA_WIDTH/1/1  data-side response.
REQ-010 wb_adr/dat_w/sel/we/cyc/stb  out  (same widths as REQ-006)  shared bus request.
REQ-011 wb_dat_r/ack/err  in  DATA_WIDTH/1/1  shared bus response.

Function
REQ-012 FSM states: IDLE, GNT_I, GNT_D, ABORT; the state register and the last-grant bit (last_d) are the only grant state.
REQ-013 IDLE transitions:
- only wbi_cyc=1 -> GNT_I.
- only wbd_cyc=1 -> GNT_D.
- both=1 -> the requester not granted last (round-robin via last_d).
- neither -> stay in IDLE.
REQ-014 Grant is registered: a request first seen in IDLE in cycle N shall drive wb_cyc/wb_stb in cycle N+1, never in cycle N.
REQ-015 In GNT_x, wb_adr/dat_w/sel/we/cyc/stb shall equal requester x's signals combinationally.
REQ-016 In IDLE and ABORT, wb_cyc=0 and wb_stb=0; wb_adr, dat_w, sel and we are don't-care.
REQ-017 wb_dat_r shall be routed to both wbi_dat_r and wbd_dat_r.
REQ-018 wb_ack/wb_err shall pass combinationally only to the granted requester; the other requester's ack/err shall be 0.
REQ-019 Grant shall be held while the granted cyc=1, including cycles with stb=0 (block/RMW lock).
REQ-020 GNT_x with cyc_x=0:
- if the other requester's cyc=1 -> GNT_other (no IDLE bubble).
- else -> IDLE.
- last_d is updated on every grant.
REQ-021 Watchdog counter (width ceil(log2(TIMEOUT+1))):
- clears on any state change and on any cycle with wb_ack or wb_err.
- increments each cycle in GNT_x with wb_stb=1.
- holds when stb=0.
REQ-022 Counter reaching TIMEOUT in GNT_x (TIMEOUT!=0):
- assert err to requester x for exactly that cycle.
- force wb_cyc=0 and wb_stb=0 the next cycle.
- enter ABORT.
REQ-023 In ABORT, all acks/errs shall be 0; wb_ack/wb_err arriving late shall be ignored; exit per REQ-020 once the aborted requester drops cyc.
REQ-024 Simultaneous wb_ack and counter reaching TIMEOUT in the same cycle: ack wins; no err, no abort.
REQ-025 wb_ack and wb_err both high shall be forwarded unchanged to the granted requester; the arbiter does not arbitrate between them.

Reset
REQ-026 While reset=0:
- state=IDLE, last_d=1 (first contended grant goes to instruction), counter=0.
- wb_cyc=0, wb_stb=0.
- all ack/err outputs 0.
REQ-027 Reset asserted mid-transfer shall drop wb_cyc/wb_stb immediately (asynchronously) with no err to requesters.
REQ-028 After reset release, arbitration resumes from IDLE on the first rising edge.

Verification
REQ-029 Single instruction fetch: wbi_cyc=stb=1, adr=0x100 at cycle 0; ack at cycle 2 with dat_r=0x00000013 -> wb_stb high cycles 1-2, wbi_ack=1 at cycle 2, wbi_dat_r=0x00000013, wbd_ack=0 throughout.
REQ-030 Contention after reset: wbi_cyc and wbd_cyc both rise at cycle 0, each holds until acked -> instruction granted first, then data follows with no IDLE cycle; a repeated contention grants data first.
REQ-031 Lock: data master holds cyc=1 with stb toggling 1,0,1 across two acked beats while wbi_cyc=1 -> wb_adr never shows the wbi_adr value until wbd_cyc=0.
REQ-032 Timeout: TIMEOUT=4, data stb=1, target never acks -> wbd_err=1 exactly one cycle, 4 cycles after stb appears on wb_; wb_cyc=0 the next cycle; a late wb_ack in ABORT is not forwarded.
REQ-033 Ack/timeout collision: TIMEOUT=3, wb_ack arrives in the cycle the counter reaches 3 -> ack forwarded, no err, state stays GNT until cyc drops.
REQ-034 Async reset at cycle 1 of a granted transfer -> wb_cyc=0 within the same cycle, all acks/errs 0; after release, a new wbd request is granted with the registered latency of REQ-014.
